// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit.
// Holds mem_op codes and the access FSM state type.
package mem_access_unit_pkg;

   localparam logic [2:0] MOP_B  = 3'b000;
   localparam logic [2:0] MOP_BU = 3'b001;
   localparam logic [2:0] MOP_H  = 3'b010;
   localparam logic [2:0] MOP_HU = 3'b011;
   localparam logic [2:0] MOP_W  = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mem_access_unit_store_lane_gen.sv
// Byte-enable / store-lane replication and legality check.
// Purely combinational; the request is judged from op, we and addr[1:0].
module store_lane_gen
   import mem_access_unit_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic        we_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic        err_o
);

   always_comb begin
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      err_o   = 1'b0;
      case (op_i)
         MOP_B, MOP_BU: begin
            if (we_i) be_o = 4'b0001 << off_i;
            wdata_o = {4{wdata_i[7:0]}};
            err_o   = we_i && (op_i == MOP_BU);
         end
         MOP_H, MOP_HU: begin
            if (we_i) be_o = off_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
            err_o   = off_i[0] || (we_i && (op_i == MOP_HU));
         end
         MOP_W: err_o = (off_i != 2'b00);
         default: err_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: single outstanding req/ack access,
// pipeline stall while in flight, raw load word to the extension unit.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  mem_op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        flush,
   output logic        stall,
   output logic        addr_err,
   output logic        bus_err,
   output logic        dm_req,
   output logic        dm_we,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        ld_valid,
   output logic [2:0]  ld_op,
   output logic [1:0]  ld_bite,
   output logic [31:0] ld_din
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               drop_q, drop_d;
   logic               dm_req_q, dm_req_d;
   logic               dm_we_q, dm_we_d;
   logic [3:0]         dm_be_q, dm_be_d;
   logic [31:0]        dm_addr_q, dm_addr_d;
   logic [31:0]        dm_wdata_q, dm_wdata_d;
   logic [2:0]         op_q, op_d;
   logic [1:0]         off_q, off_d;
   logic               addr_err_q, addr_err_d;
   logic               bus_err_q, bus_err_d;
   logic               ld_valid_q, ld_valid_d;
   logic [2:0]         ld_op_q, ld_op_d;
   logic [1:0]         ld_bite_q, ld_bite_d;
   logic [31:0]        ld_din_q, ld_din_d;

   logic [3:0]         lane_be;
   logic [31:0]        lane_wdata;
   logic               lane_err;

   store_lane_gen u_lane (
      .op_i    (mem_op),
      .we_i    (req_we),
      .off_i   (addr[1:0]),
      .wdata_i (wdata),
      .be_o    (lane_be),
      .wdata_o (lane_wdata),
      .err_o   (lane_err)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      drop_d     = drop_q;
      dm_req_d   = dm_req_q;
      dm_we_d    = dm_we_q;
      dm_be_d    = dm_be_q;
      dm_addr_d  = dm_addr_q;
      dm_wdata_d = dm_wdata_q;
      op_d       = op_q;
      off_d      = off_q;
      addr_err_d = 1'b0;
      bus_err_d  = 1'b0;
      ld_valid_d = 1'b0;
      ld_op_d    = ld_op_q;
      ld_bite_d  = ld_bite_q;
      ld_din_d   = ld_din_q;
      stall      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && !flush) begin
               stall = 1'b1;
               if (lane_err) begin
                  addr_err_d = 1'b1;
                  state_d    = ST_DONE;
               end else begin
                  dm_req_d   = 1'b1;
                  dm_we_d    = req_we;
                  dm_be_d    = lane_be;
                  dm_addr_d  = {addr[31:2], 2'b00};
                  dm_wdata_d = lane_wdata;
                  op_d       = mem_op;
                  off_d      = addr[1:0];
                  cnt_d      = '0;
                  state_d    = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            stall  = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            drop_d = drop_q | flush;
            // ack takes priority over a coincident timeout
            if (dm_ack) begin
               dm_req_d = 1'b0;
               state_d  = ST_DONE;
               if (!dm_we_q) begin
                  ld_din_d   = dm_rdata;
                  ld_op_d    = op_q;
                  ld_bite_d  = off_q;
                  ld_valid_d = !(drop_q | flush);
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               dm_req_d  = 1'b0;
               bus_err_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            drop_d  = 1'b0;
            cnt_d   = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         drop_q     <= 1'b0;
         dm_req_q   <= 1'b0;
         dm_we_q    <= 1'b0;
         dm_be_q    <= '0;
         dm_addr_q  <= '0;
         dm_wdata_q <= '0;
         op_q       <= '0;
         off_q      <= '0;
         addr_err_q <= 1'b0;
         bus_err_q  <= 1'b0;
         ld_valid_q <= 1'b0;
         ld_op_q    <= '0;
         ld_bite_q  <= '0;
         ld_din_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         drop_q     <= drop_d;
         dm_req_q   <= dm_req_d;
         dm_we_q    <= dm_we_d;
         dm_be_q    <= dm_be_d;
         dm_addr_q  <= dm_addr_d;
         dm_wdata_q <= dm_wdata_d;
         op_q       <= op_d;
         off_q      <= off_d;
         addr_err_q <= addr_err_d;
         bus_err_q  <= bus_err_d;
         ld_valid_q <= ld_valid_d;
         ld_op_q    <= ld_op_d;
         ld_bite_q  <= ld_bite_d;
         ld_din_q   <= ld_din_d;
      end
   end

   assign addr_err = addr_err_q;
   assign bus_err  = bus_err_q;
   assign dm_req   = dm_req_q;
   assign dm_we    = dm_we_q;
   assign dm_be    = dm_be_q;
   assign dm_addr  = dm_addr_q;
   assign dm_wdata = dm_wdata_q;
   assign ld_valid = ld_valid_q;
   assign ld_op    = ld_op_q;
   assign ld_bite  = ld_bite_q;
   assign ld_din   = ld_din_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed plan cases plus random traffic
// checked cycle by cycle against a transaction-level reference.
module tb_mem_access_unit;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  mem_op = '0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        flush = 1'b0;
   logic        stall, addr_err, bus_err, dm_req, dm_we;
   logic [3:0]  dm_be;
   logic [31:0] dm_addr, dm_wdata;
   logic        dm_ack = 1'b0;
   logic [31:0] dm_rdata = '0;
   logic        ld_valid;
   logic [2:0]  ld_op;
   logic [1:0]  ld_bite;
   logic [31:0] ld_din;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_we    (req_we),
      .mem_op    (mem_op),
      .addr      (addr),
      .wdata     (wdata),
      .flush     (flush),
      .stall     (stall),
      .addr_err  (addr_err),
      .bus_err   (bus_err),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_be     (dm_be),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_ack    (dm_ack),
      .dm_rdata  (dm_rdata),
      .ld_valid  (ld_valid),
      .ld_op     (ld_op),
      .ld_bite   (ld_bite),
      .ld_din    (ld_din)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int op_size(input logic [2:0] op);
      if (op == 3'd4) return 4;
      if (op >= 3'd2) return 2;
      return 1;
   endfunction

   function automatic bit ref_illegal(input logic [2:0] op, input bit we,
                                      input logic [1:0] off);
      if (op > 3'd4) return 1'b1;
      if (we && (op == 3'd1 || op == 3'd3)) return 1'b1;
      return (int'(off) % op_size(op)) != 0;
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] op, input bit we,
                                         input logic [1:0] off);
      int sz;
      if (!we) return 4'hF;
      sz = op_size(op);
      return 4'(((1 << sz) - 1) << off);
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] op,
                                             input logic [31:0] d);
      case (op_size(op))
         1:       return {24'd0, d[7:0]} * 32'h0101_0101;
         2:       return {16'd0, d[15:0]} * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   // ack_at: BUSY cycle (1-based) in which memory acks, 0 = never.
   // flush_at: BUSY cycle in which flush is raised, 0 = never.
   task automatic run_txn(input logic [2:0] op, input bit we,
                          input logic [31:0] a, input logic [31:0] d,
                          input int ack_at, input int flush_at,
                          input logic [31:0] rd);
      bit ill, acked, dropped;
      int c;
      ill = ref_illegal(op, we, a[1:0]);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      mem_op    = op;
      addr      = a;
      wdata     = d;
      flush     = 1'b0;
      #1;
      check("stall_accept", 32'(stall), 32'd1);
      if (ill) begin
         @(negedge clk);
         check("addr_err", 32'(addr_err), 32'd1);
         check("err_stall", 32'(stall), 32'd0);
         check("err_dm_req", 32'(dm_req), 32'd0);
         check("err_ld_valid", 32'(ld_valid), 32'd0);
         req_valid = 1'b0;
         @(negedge clk);
         check("addr_err_pulse", 32'(addr_err), 32'd0);
         check("err_idle_req", 32'(dm_req), 32'd0);
         return;
      end
      acked   = 1'b0;
      dropped = 1'b0;
      c       = 0;
      while (c < TIMEOUT + 2) begin
         @(negedge clk);
         c++;
         check("busy_dm_req", 32'(dm_req), 32'd1);
         check("busy_stall", 32'(stall), 32'd1);
         check("busy_bus_err", 32'(bus_err), 32'd0);
         if (c == 1) begin
            check("dm_addr", dm_addr, {a[31:2], 2'b00});
            check("dm_we", 32'(dm_we), 32'(we));
            check("dm_be", 32'(dm_be), 32'(ref_be(op, we, a[1:0])));
            if (we) check("dm_wdata", dm_wdata, ref_wdata(op, d));
         end
         dm_ack   = (c == ack_at);
         dm_rdata = rd;
         flush    = (c == flush_at);
         if (flush) dropped = 1'b1;
         if (dm_ack) acked = 1'b1;
         if (dm_ack || c == TIMEOUT) break;
      end
      if (c >= TIMEOUT + 2) check("busy_bound", 32'(c), 32'(TIMEOUT));
      @(negedge clk);
      dm_ack = 1'b0;
      flush  = 1'b0;
      check("done_stall", 32'(stall), 32'd0);
      check("done_dm_req", 32'(dm_req), 32'd0);
      check("bus_err", 32'(bus_err), 32'(!acked));
      check("done_addr_err", 32'(addr_err), 32'd0);
      check("ld_valid", 32'(ld_valid), 32'(acked && !we && !dropped));
      if (acked && !we && !dropped) begin
         check("ld_op", 32'(ld_op), 32'(op));
         check("ld_bite", 32'(ld_bite), 32'(a[1:0]));
         check("ld_din", ld_din, rd);
      end
      req_valid = 1'b0;
      @(negedge clk);
      check("idle_ld_valid", 32'(ld_valid), 32'd0);
      check("idle_bus_err", 32'(bus_err), 32'd0);
      check("idle_stall", 32'(stall), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_dm_req", 32'(dm_req), 32'd0);
      check("rst_dm_be", 32'(dm_be), 32'd0);
      check("rst_ld_valid", 32'(ld_valid), 32'd0);
      check("rst_ld_din", ld_din, 32'd0);

      run_txn(3'd0, 1'b1, 32'h0000_1003, 32'hAABB_CCDD, 1, 0, 32'h0);
      run_txn(3'd2, 1'b0, 32'h0000_2002, 32'h0, 3, 0, 32'h8001_1234);
      run_txn(3'd4, 1'b0, 32'h0000_3001, 32'h0, 1, 0, 32'h0);
      run_txn(3'd4, 1'b0, 32'h0000_3000, 32'h0, 0, 0, 32'h0);
      run_txn(3'd4, 1'b0, 32'h0000_3004, 32'h0, TIMEOUT, 0, 32'hCAFE_F00D);
      run_txn(3'd1, 1'b0, 32'h0000_5005, 32'h0, 3, 2, 32'h1111_2222);
      run_txn(3'd1, 1'b0, 32'h0000_5006, 32'h0, 1, 0, 32'h3333_4444);
      run_txn(3'd2, 1'b1, 32'h0000_6002, 32'h1234_5678, 2, 0, 32'h0);
      run_txn(3'd3, 1'b1, 32'h0000_6000, 32'h0, 1, 0, 32'h0);
      run_txn(3'd5, 1'b0, 32'h0000_6000, 32'h0, 1, 0, 32'h0);

      for (int i = 0; i < 60; i++) begin
         int ack_at, flush_at;
         ack_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT))
                                             : int'($urandom_range(1, 4));
         flush_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
         run_txn(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, ack_at, flush_at, $urandom);
      end

      run_txn(3'd4, 1'b0, 32'h0000_7000, 32'h0, 1, 0, 32'h5A5A_A5A5);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      mem_op    = 3'd4;
      addr      = 32'h0000_8000;
      repeat (2) @(negedge clk);
      check("mid_busy_req", 32'(dm_req), 32'd1);
      rst       = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      check("rst_busy_req", 32'(dm_req), 32'd0);
      check("rst_busy_stall", 32'(stall), 32'd0);
      check("rst_busy_addr", dm_addr, 32'd0);
      check("rst_busy_ld_din", ld_din, 32'd0);
      check("rst_busy_be", 32'(dm_be), 32'd0);
      rst = 1'b0;
      run_txn(3'd4, 1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 2, 0, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
